// File: rtl/fetch_pkg.sv
// Shared fetch-side types and constants used by the instruction queue and its storage.
package fetch_pkg;

    localparam int INST_QUEUE_DEPTH = 4;
    localparam logic [31:0] NOP_INST = 32'h0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch/decode-facing handshake bundle of the instruction queue; the queue takes the slave view.
interface inst_queue_if #(
    parameter int DEPTH = 4
);
    localparam int PTR_W = $clog2(DEPTH);

    logic             fetch_issue;
    logic             fetch_ok;
    logic             resp_valid;
    logic [31:0]      resp_inst;
    logic [31:0]      resp_pc;
    logic             flush;
    logic             id_valid;
    logic [31:0]      id_inst;
    logic [31:0]      id_pc;
    logic             id_ready;
    logic [PTR_W:0]   count;

    modport master (
        output fetch_issue, resp_valid, resp_inst, resp_pc, flush, id_ready,
        input  fetch_ok, id_valid, id_inst, id_pc, count
    );

    modport slave (
        input  fetch_issue, resp_valid, resp_inst, resp_pc, flush, id_ready,
        output fetch_ok, id_valid, id_inst, id_pc, count
    );

endinterface

// File: rtl/inst_queue_mem.sv
// Register-array storage for the instruction queue: one synchronous write port, one asynchronous read port.
module inst_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  fetch_entry_t     wdata,
    input  logic [PTR_W-1:0] raddr,
    output fetch_entry_t     rdata
);

    fetch_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue with fetch credits and post-flush response dropping.
// Optional INST_QUEUE_BYPASS_EN: empty-queue responses reach decode in the same cycle.
module inst_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = INST_QUEUE_DEPTH
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W+1:0] DEPTH_W = DEPTH[PTR_W+1:0];

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count_q, outstanding, outstanding_next, drop;
    logic [PTR_W+1:0] occupancy;
    logic             stored_valid, bypass, push, pop;
    fetch_entry_t     head, wdata;

    assign outstanding_next = outstanding + {{PTR_W{1'b0}}, q.fetch_issue}
                                          - {{PTR_W{1'b0}}, q.resp_valid};
    assign occupancy    = {1'b0, count_q} + {1'b0, outstanding};
    assign q.fetch_ok   = (occupancy < DEPTH_W) && !q.flush;
    assign stored_valid = (count_q != '0);

`ifdef INST_QUEUE_BYPASS_EN
    assign bypass = (count_q == '0) && (drop == '0) && !q.flush && q.resp_valid;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed entry taken by decode in the same cycle never enters storage.
    assign push  = q.resp_valid && !q.flush && (drop == '0) && !(bypass && q.id_ready);
    assign pop   = stored_valid && q.id_ready && !q.flush;
    assign wdata = '{pc: q.resp_pc, inst: q.resp_inst};

    inst_queue_mem #(.DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign q.id_valid = stored_valid || bypass;
    assign q.count    = count_q;

    always_comb begin
        q.id_inst = NOP_INST;
        q.id_pc   = 32'h0;
        if (bypass) begin
            q.id_inst = q.resp_inst;
            q.id_pc   = q.resp_pc;
        end else if (stored_valid) begin
            q.id_inst = head.inst;
            q.id_pc   = head.pc;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (q.flush) begin
                // Everything still in flight at the flush is stale, including a same-cycle issue.
                count_q <= '0;
                rd_ptr  <= wr_ptr;
                drop    <= outstanding_next;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (push && !pop) begin
                    count_q <= count_q + 1'b1;
                end else if (pop && !push) begin
                    count_q <= count_q - 1'b1;
                end
                if (q.resp_valid && (drop != '0)) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

    // The fetch stage may see fetch_ok drop combinationally on flush, so only the occupancy part is enforced.
    a_issue_credit: assert property (@(posedge clk) disable iff (!rst)
        q.fetch_issue |-> (occupancy < DEPTH_W));

    a_resp_outstanding: assert property (@(posedge clk) disable iff (!rst)
        q.resp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue; expectations follow INST_QUEUE_BYPASS_EN when defined.
module tb_inst_queue;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    inst_queue_if #(.DEPTH(4)) bus ();

    inst_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic fi, input logic rv, input logic [31:0] pc,
                                 input logic [31:0] inst, input logic fl);
        bus.fetch_issue = fi;
        bus.resp_valid  = rv;
        bus.resp_pc     = pc;
        bus.resp_inst   = inst;
        bus.flush       = fl;
    endtask

    // Pulse inputs last exactly one edge; outputs are then sampled well clear of the next edge.
    task automatic clockEdge();
        @(posedge clk);
        #1;
        bus.fetch_issue = 1'b0;
        bus.resp_valid  = 1'b0;
        bus.flush       = 1'b0;
        #1;
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        bus.id_ready = 1'b0;

        #12;
        checkOutput("reset_count", 32'(bus.count), 32'd0);
        checkOutput("reset_id_valid", 32'(bus.id_valid), 32'd0);
        checkOutput("reset_id_pc", bus.id_pc, 32'h0);
        checkOutput("reset_id_inst", bus.id_inst, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("reset_fetch_ok", 32'(bus.fetch_ok), 32'd1);

        // Single fetch, response two cycles after issue, decode ready.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        clockEdge();
        bus.id_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'hBFC00000, 32'h24080001, 1'b0);
        #1;
`ifdef INST_QUEUE_BYPASS_EN
        checkOutput("byp_id_valid", 32'(bus.id_valid), 32'd1);
        checkOutput("byp_id_pc", bus.id_pc, 32'hBFC00000);
        checkOutput("byp_id_inst", bus.id_inst, 32'h24080001);
        clockEdge();
        checkOutput("byp_count", 32'(bus.count), 32'd0);
        checkOutput("byp_after_valid", 32'(bus.id_valid), 32'd0);
`else
        checkOutput("nobyp_same_cycle", 32'(bus.id_valid), 32'd0);
        clockEdge();
        checkOutput("t1_id_valid", 32'(bus.id_valid), 32'd1);
        checkOutput("t1_id_pc", bus.id_pc, 32'hBFC00000);
        checkOutput("t1_id_inst", bus.id_inst, 32'h24080001);
        checkOutput("t1_count", 32'(bus.count), 32'd1);
        clockEdge();
        checkOutput("t1_popped_count", 32'(bus.count), 32'd0);
        checkOutput("t1_popped_valid", 32'(bus.id_valid), 32'd0);
`endif
        bus.id_ready = 1'b0;

        // Fill to capacity with decode stalled, then drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            clockEdge();
            if (i == 0) checkOutput("fill_ok_1", 32'(bus.fetch_ok), 32'd1);
        end
        checkOutput("fill_ok_4", 32'(bus.fetch_ok), 32'd0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 32'hBFC00000 + 32'(4 * i), 32'h100 + 32'(i), 1'b0);
            clockEdge();
        end
        checkOutput("fill_count", 32'(bus.count), 32'd4);
        checkOutput("fill_ok_full", 32'(bus.fetch_ok), 32'd0);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_pc", bus.id_pc, 32'hBFC00000 + 32'(4 * i));
            checkOutput("drain_inst", bus.id_inst, 32'h100 + 32'(i));
            clockEdge();
        end
        checkOutput("drain_count", 32'(bus.count), 32'd0);
        checkOutput("drain_ok", 32'(bus.fetch_ok), 32'd1);
        bus.id_ready = 1'b0;

        // Two fetches in flight, flush, both late responses dropped.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #1;
        checkOutput("flush_ok_low", 32'(bus.fetch_ok), 32'd0);
        clockEdge();
        checkOutput("flush_drop2", 32'(dut.drop), 32'd2);
        applyStimulus(1'b0, 1'b1, 32'hDEAD0000, 32'hDEAD0001, 1'b0);
        #1;
        checkOutput("drop_no_bypass", 32'(bus.id_valid), 32'd0);
        clockEdge();
        checkOutput("drop1_valid", 32'(bus.id_valid), 32'd0);
        checkOutput("drop1", 32'(dut.drop), 32'd1);
        applyStimulus(1'b0, 1'b1, 32'hDEAD0004, 32'hDEAD0005, 1'b0);
        clockEdge();
        checkOutput("drop0", 32'(dut.drop), 32'd0);
        checkOutput("drop0_count", 32'(bus.count), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b1, 32'h80000000, 32'h00000011, 1'b0);
        clockEdge();
        checkOutput("after_drop_count", 32'(bus.count), 32'd1);
        checkOutput("after_drop_pc", bus.id_pc, 32'h80000000);
        bus.id_ready = 1'b1;
        clockEdge();
        bus.id_ready = 1'b0;
        checkOutput("after_drop_pop", 32'(bus.count), 32'd0);

        // Flush coinciding with issue and response while one fetch is outstanding.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        applyStimulus(1'b1, 1'b1, 32'hC0000000, 32'hC0000001, 1'b1);
        clockEdge();
        checkOutput("coflush_drop", 32'(dut.drop), 32'd1);
        checkOutput("coflush_count", 32'(bus.count), 32'd0);
        checkOutput("coflush_valid", 32'(bus.id_valid), 32'd0);
        applyStimulus(1'b0, 1'b1, 32'hC0000004, 32'hC0000005, 1'b0);
        clockEdge();
        checkOutput("coflush_drop0", 32'(dut.drop), 32'd0);
        checkOutput("coflush_count0", 32'(bus.count), 32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b1, 32'h90000000, 32'h00000022, 1'b0);
        clockEdge();
        checkOutput("coflush_queued", 32'(bus.count), 32'd1);
        checkOutput("coflush_pc", bus.id_pc, 32'h90000000);

        // Second entry, then simultaneous push and pop.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        applyStimulus(1'b0, 1'b1, 32'hA0000000, 32'h00000033, 1'b0);
        clockEdge();
        checkOutput("two_count", 32'(bus.count), 32'd2);
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        clockEdge();
        bus.id_ready = 1'b1;
        applyStimulus(1'b0, 1'b1, 32'hB0000000, 32'h00000044, 1'b0);
        clockEdge();
        bus.id_ready = 1'b0;
        checkOutput("pushpop_count", 32'(bus.count), 32'd2);
        checkOutput("pushpop_head", bus.id_pc, 32'hA0000000);
        checkOutput("pushpop_inst", bus.id_inst, 32'h00000033);

        // Asynchronous reset between clock edges with a transfer in progress.
        applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        checkOutput("async_count", 32'(bus.count), 32'd0);
        checkOutput("async_valid", 32'(bus.id_valid), 32'd0);
        checkOutput("async_pc", bus.id_pc, 32'h0);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        rst = 1'b1;
        clockEdge();
        checkOutput("post_reset_count", 32'(bus.count), 32'd0);
        checkOutput("post_reset_ok", 32'(bus.fetch_ok), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
